rs_param: RTL and testbench
===========================

RS_PARAM -- requirements
Module: rs_param

Interface
REQ-001 Parameter DEPTH, default 8, number of entries, power of 2, at least 2.
REQ-002 Parameter CDB_PORTS, default 2, number of result broadcast ports.
REQ-003 Parameters ROB_WIDTH 4, DATA_WIDTH 32, OP_WIDTH 6, ADDR_WIDTH 32 (defaults); tag 0 means "no dependence".
REQ-004 clk_in  input  1  clock; one clock domain.
REQ-005 rst_n_in  input  1  reset, synchronous and active-low.
REQ-006 rdy_in  input  1  global enable; low freezes all state.
REQ-007 flush_in  input  1  mispredict flush; drops all contents.
REQ-008 dp_valid_in  input  1  dispatch request.
REQ-009 dp_op_in / dp_pc_in / dp_imm_in / dp_rob_id_in  input  OP_WIDTH/ADDR_WIDTH/DATA_WIDTH/ROB_WIDTH  dispatched op, pc, immediate, destination tag.
REQ-010 dp_qj_in, dp_qk_in  input  ROB_WIDTH each  source tags; dp_vj_in, dp_vk_in  input  DATA_WIDTH each  source values.
REQ-011 full_out  output  1  high when all DEPTH entries are occupied.
REQ-012 cdb_valid_in  input  CDB_PORTS  per-port broadcast valid; cdb_tag_in  input  CDB_PORTS*ROB_WIDTH; cdb_data_in  input  CDB_PORTS*DATA_WIDTH; port p occupies slice p.
REQ-013 iss_valid_out  output  1  issue register valid; iss_ready_in  input  1  ALU accepts.
REQ-014 iss_op_out, iss_pc_out, iss_vj_out, iss_vk_out, iss_imm_out, iss_rob_id_out  output  issued fields, same widths as the dispatch fields.
REQ-015 count_out  output  $clog2(DEPTH)+1  occupied entries (issue register excluded).

Function
REQ-016 Entry state: busy, op, pc, qj, qk, vj, vk, imm, rob_id, plus a DEPTH x DEPTH age matrix in which older[i][j]=1 means entry j is older than entry i.
REQ-017 Dispatch: when dp_valid_in && !full_out, the design writes the lowest-index free entry and sets older[s][j]=busy[j] for all j.
REQ-018 Dispatch while full_out is high is ignored with no state change (dispatcher protocol violation).
REQ-019 Wakeup: for each busy entry and each port p with cdb_valid_in[p], a nonzero qj equal to tag p sets qj=0 and vj=data p; qk/vk likewise.
REQ-020 Dispatch bypass: the same match is applied to dp_qj_in/dp_qk_in in the dispatch cycle, so the entry is written already resolved.
REQ-021 Multiple ports matching one tag: the highest-index port wins; the ROB does not produce this.
REQ-022 Ready entry: busy && qj==0 && qk==0, evaluated on registered state; an entry woken at edge N is issuable from cycle N+1.
REQ-023 Selection is oldest-first: pick the ready entry i for which no other ready entry j has older[i][j]=1.
REQ-024 Issue register load: when !iss_valid_out || iss_ready_in, and a ready entry exists, the selected entry is copied into the iss_* registers, iss_valid_out is set, and the entry is freed at the same edge.
REQ-025 If that load condition holds and no ready entry exists, iss_valid_out clears.
REQ-026 While iss_valid_out && !iss_ready_in, all iss_* outputs hold stable.
REQ-027 Latency: an entry dispatched ready at edge N drives iss_valid_out at edge N+1 (if the issue register is free and the entry is oldest).
REQ-028 Freeing an entry clears its age column (older[*][s]=0).
REQ-029 count_out increments on dispatch and decrements on issue-load; simultaneous dispatch and issue leaves it unchanged; full_out = (count_out == DEPTH), registered.
REQ-030 A slot freed at edge N is reusable from cycle N+1; there is no same-cycle reuse.
REQ-031 Flush: when rdy_in && flush_in, all busy bits, the age matrix, count_out and iss_valid_out clear; a same-cycle dispatch, issue handshake or CDB is discarded.
REQ-032 rdy_in low: no state changes, outputs hold, and the iss_ready_in handshake is not consumed.
REQ-033 Precedence per edge: reset > !rdy_in > flush_in > normal operation.

Reset
REQ-034 On a clk_in edge with rst_n_in low: all busy=0, age matrix 0, count_out=0, full_out=0, iss_valid_out=0, all other iss_* outputs 0.
REQ-035 Reset is honoured regardless of rdy_in.

Verification
REQ-036 Dispatch tag 5 with qj=qk=0, vj=3, vk=4, op ADD, iss_ready_in=1 -> next cycle iss_valid_out=1, iss_rob_id_out=5, iss_vj_out=3, count_out back to 0.
REQ-037 Dispatch tag 1 (qj=7), then tag 2 (ready), then tag 3 (ready), iss_ready_in=0 -> tag 2 is held in the issue register; CDB tag 7 data 0x55; raise iss_ready_in -> issue order is 2, 3, then 1 with vj=0x55.
REQ-038 Dispatch qk=9 in the same cycle that CDB port 1 broadcasts tag 9 with 0xAB -> entry issues next cycle with vk=0xAB.
REQ-039 Fill DEPTH entries each with qj=6 -> full_out=1 and a further dispatch is ignored; broadcast tag 6 -> issues in dispatch order, full_out drops after the first issue-load.
REQ-040 Hold iss_ready_in=0 for 5 cycles with a valid issue -> outputs remain stable; then flush_in -> iss_valid_out=0, count_out=0, full_out=0.
REQ-041 Drive rst_n_in low for one edge mid-stream with rdy_in=0 -> all REQ-034 values; first dispatch afterwards lands in entry 0.

Source files
------------

// File: rtl/rs_param.sv
// Reservation station: holds dispatched ops until both sources are resolved,
// wakes them from the CDB, and issues the oldest ready entry into a one-deep
// issue register towards the ALU.
module rs_param #(
    parameter int DEPTH      = 8,
    parameter int CDB_PORTS  = 2,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            rdy_in,
    input  logic                            flush_in,
    input  logic                            dp_valid_in,
    input  logic [OP_WIDTH-1:0]             dp_op_in,
    input  logic [ADDR_WIDTH-1:0]           dp_pc_in,
    input  logic [DATA_WIDTH-1:0]           dp_imm_in,
    input  logic [ROB_WIDTH-1:0]            dp_rob_id_in,
    input  logic [ROB_WIDTH-1:0]            dp_qj_in,
    input  logic [ROB_WIDTH-1:0]            dp_qk_in,
    input  logic [DATA_WIDTH-1:0]           dp_vj_in,
    input  logic [DATA_WIDTH-1:0]           dp_vk_in,
    output logic                            full_out,
    input  logic [CDB_PORTS-1:0]            cdb_valid_in,
    input  logic [CDB_PORTS*ROB_WIDTH-1:0]  cdb_tag_in,
    input  logic [CDB_PORTS*DATA_WIDTH-1:0] cdb_data_in,
    output logic                            iss_valid_out,
    input  logic                            iss_ready_in,
    output logic [OP_WIDTH-1:0]             iss_op_out,
    output logic [ADDR_WIDTH-1:0]           iss_pc_out,
    output logic [DATA_WIDTH-1:0]           iss_vj_out,
    output logic [DATA_WIDTH-1:0]           iss_vk_out,
    output logic [DATA_WIDTH-1:0]           iss_imm_out,
    output logic [ROB_WIDTH-1:0]            iss_rob_id_out,
    output logic [$clog2(DEPTH):0]          count_out
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      older [DEPTH];
    logic [OP_WIDTH-1:0]   e_op  [DEPTH];
    logic [ADDR_WIDTH-1:0] e_pc  [DEPTH];
    logic [DATA_WIDTH-1:0] e_imm [DEPTH];
    logic [ROB_WIDTH-1:0]  e_rob [DEPTH];
    logic [ROB_WIDTH-1:0]  e_qj  [DEPTH];
    logic [ROB_WIDTH-1:0]  e_qk  [DEPTH];
    logic [DATA_WIDTH-1:0] e_vj  [DEPTH];
    logic [DATA_WIDTH-1:0] e_vk  [DEPTH];

    logic [ROB_WIDTH-1:0]  w_qj [DEPTH];
    logic [ROB_WIDTH-1:0]  w_qk [DEPTH];
    logic [DATA_WIDTH-1:0] w_vj [DEPTH];
    logic [DATA_WIDTH-1:0] w_vk [DEPTH];
    logic [ROB_WIDTH-1:0]  d_qj, d_qk;
    logic [DATA_WIDTH-1:0] d_vj, d_vk;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] issue_oh;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             any_ready;
    logic             iss_load;
    logic             do_issue;
    logic             do_disp;
    logic [CNT_W-1:0] count_nxt;

    // CDB wakeup for stored entries and dispatch bypass; later ports override earlier ones
    always_comb begin
        d_qj = dp_qj_in;
        d_qk = dp_qk_in;
        d_vj = dp_vj_in;
        d_vk = dp_vk_in;
        for (int i = 0; i < DEPTH; i++) begin
            w_qj[i] = e_qj[i];
            w_qk[i] = e_qk[i];
            w_vj[i] = e_vj[i];
            w_vk[i] = e_vk[i];
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid_in[p]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (e_qj[i] != '0 && e_qj[i] == cdb_tag_in[p*ROB_WIDTH +: ROB_WIDTH]) begin
                        w_qj[i] = '0;
                        w_vj[i] = cdb_data_in[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                    if (e_qk[i] != '0 && e_qk[i] == cdb_tag_in[p*ROB_WIDTH +: ROB_WIDTH]) begin
                        w_qk[i] = '0;
                        w_vk[i] = cdb_data_in[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (dp_qj_in != '0 && dp_qj_in == cdb_tag_in[p*ROB_WIDTH +: ROB_WIDTH]) begin
                    d_qj = '0;
                    d_vj = cdb_data_in[p*DATA_WIDTH +: DATA_WIDTH];
                end
                if (dp_qk_in != '0 && dp_qk_in == cdb_tag_in[p*ROB_WIDTH +: ROB_WIDTH]) begin
                    d_qk = '0;
                    d_vk = cdb_data_in[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Oldest-ready selection, lowest free slot, and issue/dispatch control
    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy[i] && (e_qj[i] == '0) && (e_qk[i] == '0);
        end
        any_ready = |ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i] && !(|(older[i] & ready))) begin
                sel_idx = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
        iss_load = !iss_valid_out || iss_ready_in;
        do_issue = iss_load && any_ready;
        do_disp  = dp_valid_in && !full_out;
        for (int i = 0; i < DEPTH; i++) begin
            issue_oh[i] = do_issue && (sel_idx == IDX_W'(i));
        end
        count_nxt = count_out + CNT_W'(do_disp) - CNT_W'(do_issue);
    end

    // Entry storage, age matrix, issue register and occupancy
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy           <= '0;
            count_out      <= '0;
            full_out       <= 1'b0;
            iss_valid_out  <= 1'b0;
            iss_op_out     <= '0;
            iss_pc_out     <= '0;
            iss_vj_out     <= '0;
            iss_vk_out     <= '0;
            iss_imm_out    <= '0;
            iss_rob_id_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy          <= '0;
                count_out     <= '0;
                full_out      <= 1'b0;
                iss_valid_out <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    older[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i]) begin
                        e_qj[i] <= w_qj[i];
                        e_qk[i] <= w_qk[i];
                        e_vj[i] <= w_vj[i];
                        e_vk[i] <= w_vk[i];
                    end
                    older[i] <= older[i] & ~issue_oh;
                end
                if (do_issue) begin
                    busy[sel_idx]  <= 1'b0;
                    iss_valid_out  <= 1'b1;
                    iss_op_out     <= e_op[sel_idx];
                    iss_pc_out     <= e_pc[sel_idx];
                    iss_vj_out     <= e_vj[sel_idx];
                    iss_vk_out     <= e_vk[sel_idx];
                    iss_imm_out    <= e_imm[sel_idx];
                    iss_rob_id_out <= e_rob[sel_idx];
                end else if (iss_load) begin
                    iss_valid_out <= 1'b0;
                end
                if (do_disp) begin
                    busy[free_idx]  <= 1'b1;
                    e_op[free_idx]  <= dp_op_in;
                    e_pc[free_idx]  <= dp_pc_in;
                    e_imm[free_idx] <= dp_imm_in;
                    e_rob[free_idx] <= dp_rob_id_in;
                    e_qj[free_idx]  <= d_qj;
                    e_qk[free_idx]  <= d_qk;
                    e_vj[free_idx]  <= d_vj;
                    e_vk[free_idx]  <= d_vk;
                    older[free_idx] <= busy & ~issue_oh;
                end
                count_out <= count_nxt;
                full_out  <= (count_nxt == CNT_W'(DEPTH));
            end
        end
    end

endmodule

// File: tb/tb_rs_param.sv
// Directed bench for rs_param: dispatch, wakeup, bypass, ordering, full,
// hold, flush, rdy freeze and reset.
module tb_rs_param;

    localparam int DEPTH = 8;
    localparam int CDBP  = 2;
    localparam int RW    = 4;
    localparam int DW    = 32;
    localparam int OW    = 6;
    localparam int AW    = 32;

    logic              clk_in = 1'b0;
    logic              rst_n_in, rdy_in, flush_in, dp_valid_in;
    logic [OW-1:0]     dp_op_in;
    logic [AW-1:0]     dp_pc_in;
    logic [DW-1:0]     dp_imm_in, dp_vj_in, dp_vk_in;
    logic [RW-1:0]     dp_rob_id_in, dp_qj_in, dp_qk_in;
    logic              full_out;
    logic [CDBP-1:0]   cdb_valid_in;
    logic [CDBP*RW-1:0] cdb_tag_in;
    logic [CDBP*DW-1:0] cdb_data_in;
    logic              iss_valid_out, iss_ready_in;
    logic [OW-1:0]     iss_op_out;
    logic [AW-1:0]     iss_pc_out;
    logic [DW-1:0]     iss_vj_out, iss_vk_out, iss_imm_out;
    logic [RW-1:0]     iss_rob_id_out;
    logic [$clog2(DEPTH):0] count_out;

    int checks = 0;
    int errors = 0;

    rs_param #(.DEPTH(DEPTH), .CDB_PORTS(CDBP), .ROB_WIDTH(RW), .DATA_WIDTH(DW),
               .OP_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .dp_valid_in(dp_valid_in), .dp_op_in(dp_op_in), .dp_pc_in(dp_pc_in),
        .dp_imm_in(dp_imm_in), .dp_rob_id_in(dp_rob_id_in), .dp_qj_in(dp_qj_in),
        .dp_qk_in(dp_qk_in), .dp_vj_in(dp_vj_in), .dp_vk_in(dp_vk_in),
        .full_out(full_out), .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
        .cdb_data_in(cdb_data_in), .iss_valid_out(iss_valid_out),
        .iss_ready_in(iss_ready_in), .iss_op_out(iss_op_out), .iss_pc_out(iss_pc_out),
        .iss_vj_out(iss_vj_out), .iss_vk_out(iss_vk_out), .iss_imm_out(iss_imm_out),
        .iss_rob_id_out(iss_rob_id_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic dp(input int rob, input int qj, input int qk, input int vj, input int vk);
        dp_valid_in  = 1'b1;
        dp_rob_id_in = RW'(rob);
        dp_op_in     = OW'(rob + 1);
        dp_pc_in     = AW'(32'h1000 + rob * 4);
        dp_imm_in    = DW'(rob * 3);
        dp_qj_in     = RW'(qj);
        dp_qk_in     = RW'(qk);
        dp_vj_in     = DW'(vj);
        dp_vk_in     = DW'(vk);
    endtask

    task automatic cdb(input int p, input int tag, input int data);
        cdb_valid_in[p]            = 1'b1;
        cdb_tag_in[p*RW +: RW]     = RW'(tag);
        cdb_data_in[p*DW +: DW]    = DW'(data);
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; dp_valid_in = 1'b0;
        dp_op_in = '0; dp_pc_in = '0; dp_imm_in = '0; dp_rob_id_in = '0;
        dp_qj_in = '0; dp_qk_in = '0; dp_vj_in = '0; dp_vk_in = '0;
        cdb_valid_in = '0; cdb_tag_in = '0; cdb_data_in = '0; iss_ready_in = 1'b0;

        // reset values
        step(); step();
        chk("rst_valid", 64'(iss_valid_out), 64'd0);
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_full",  64'(full_out), 64'd0);
        chk("rst_rob",   64'(iss_rob_id_out), 64'd0);
        rst_n_in = 1'b1;

        // single ready dispatch issues one edge later
        iss_ready_in = 1'b1;
        dp(5, 0, 0, 3, 4);
        step();
        chk("t1_valid_pre", 64'(iss_valid_out), 64'd0);
        chk("t1_count_pre", 64'(count_out), 64'd1);
        dp_valid_in = 1'b0;
        step();
        chk("t1_valid", 64'(iss_valid_out), 64'd1);
        chk("t1_rob",   64'(iss_rob_id_out), 64'd5);
        chk("t1_vj",    64'(iss_vj_out), 64'd3);
        chk("t1_vk",    64'(iss_vk_out), 64'd4);
        chk("t1_op",    64'(iss_op_out), 64'd6);
        chk("t1_pc",    64'(iss_pc_out), 64'h1014);
        chk("t1_imm",   64'(iss_imm_out), 64'd15);
        chk("t1_count", 64'(count_out), 64'd0);
        step();
        chk("t1_drain", 64'(iss_valid_out), 64'd0);

        // age ordering with a late wakeup
        iss_ready_in = 1'b0;
        dp(1, 7, 0, 0, 1); step();
        dp(2, 0, 0, 32'h22, 2); step();
        dp(3, 0, 0, 32'h33, 3); step();
        dp_valid_in = 1'b0;
        chk("t2_rob2",   64'(iss_rob_id_out), 64'd2);
        chk("t2_count",  64'(count_out), 64'd2);
        step();
        chk("t2_hold2",  64'(iss_rob_id_out), 64'd2);
        cdb(0, 7, 32'h55);
        iss_ready_in = 1'b1;
        step();
        cdb_valid_in = '0;
        chk("t2_rob3",   64'(iss_rob_id_out), 64'd3);
        chk("t2_vj3",    64'(iss_vj_out), 64'h33);
        step();
        chk("t2_rob1",   64'(iss_rob_id_out), 64'd1);
        chk("t2_vj1",    64'(iss_vj_out), 64'h55);
        chk("t2_count0", 64'(count_out), 64'd0);
        step();
        chk("t2_drain",  64'(iss_valid_out), 64'd0);

        // dispatch bypass from CDB port 1, non-matching port 0
        dp(4, 0, 9, 1, 0);
        cdb(0, 8, 32'h11);
        cdb(1, 9, 32'hAB);
        step();
        dp_valid_in = 1'b0; cdb_valid_in = '0;
        step();
        chk("t3_valid", 64'(iss_valid_out), 64'd1);
        chk("t3_rob",   64'(iss_rob_id_out), 64'd4);
        chk("t3_vk",    64'(iss_vk_out), 64'hAB);
        chk("t3_vj",    64'(iss_vj_out), 64'd1);
        step();
        chk("t3_drain", 64'(iss_valid_out), 64'd0);

        // fill, ignored dispatch when full, wakeup and ordered drain
        iss_ready_in = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            dp(8 + k, 6, 0, 0, k);
            step();
        end
        chk("t4_full",  64'(full_out), 64'd1);
        chk("t4_count", 64'(count_out), 64'd8);
        dp(1, 0, 0, 32'hEE, 0);
        step();
        dp_valid_in = 1'b0;
        chk("t4_ign_count", 64'(count_out), 64'd8);
        chk("t4_ign_full",  64'(full_out), 64'd1);
        cdb(0, 6, 32'h66);
        step();
        cdb_valid_in = '0;
        chk("t4_nowake_valid", 64'(iss_valid_out), 64'd0);
        step();
        chk("t4_first_rob",  64'(iss_rob_id_out), 64'd8);
        chk("t4_first_vj",   64'(iss_vj_out), 64'h66);
        chk("t4_full_drop",  64'(full_out), 64'd0);
        chk("t4_count7",     64'(count_out), 64'd7);
        iss_ready_in = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
            step();
            chk("t4_order_rob", 64'(iss_rob_id_out), 64'(8 + k));
            chk("t4_order_vk",  64'(iss_vk_out), 64'(k));
            chk("t4_order_cnt", 64'(count_out), 64'(DEPTH - 1 - k));
        end
        step();
        chk("t4_drain", 64'(iss_valid_out), 64'd0);

        // hold stability, rdy freeze, flush
        iss_ready_in = 1'b0;
        dp(12, 0, 0, 32'h77, 0); step();
        dp(13, 3, 0, 0, 0); step();
        dp_valid_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", 64'(iss_valid_out), 64'd1);
            chk("t5_hold_rob",   64'(iss_rob_id_out), 64'd12);
            chk("t5_hold_vj",    64'(iss_vj_out), 64'h77);
            chk("t5_hold_count", 64'(count_out), 64'd1);
            step();
        end
        rdy_in = 1'b0; iss_ready_in = 1'b1;
        step();
        chk("t5_frz_valid", 64'(iss_valid_out), 64'd1);
        chk("t5_frz_rob",   64'(iss_rob_id_out), 64'd12);
        chk("t5_frz_count", 64'(count_out), 64'd1);
        rdy_in = 1'b1; iss_ready_in = 1'b0;
        flush_in = 1'b1;
        dp(14, 0, 0, 5, 5);
        step();
        flush_in = 1'b0; dp_valid_in = 1'b0;
        chk("t5_fl_valid", 64'(iss_valid_out), 64'd0);
        chk("t5_fl_count", 64'(count_out), 64'd0);
        chk("t5_fl_full",  64'(full_out), 64'd0);
        step();
        chk("t5_fl_nodisp", 64'(iss_valid_out), 64'd0);

        // reset mid-stream with rdy low
        dp(2, 5, 0, 0, 0); step();
        dp(3, 0, 0, 32'h33, 0); step();
        dp_valid_in = 1'b0;
        step();
        chk("t6_pre_rob", 64'(iss_rob_id_out), 64'd3);
        rdy_in = 1'b0; rst_n_in = 1'b0;
        step();
        chk("t6_valid", 64'(iss_valid_out), 64'd0);
        chk("t6_count", 64'(count_out), 64'd0);
        chk("t6_full",  64'(full_out), 64'd0);
        chk("t6_rob",   64'(iss_rob_id_out), 64'd0);
        chk("t6_vj",    64'(iss_vj_out), 64'd0);
        chk("t6_op",    64'(iss_op_out), 64'd0);
        chk("t6_pc",    64'(iss_pc_out), 64'd0);
        rst_n_in = 1'b1; rdy_in = 1'b1;
        dp(10, 0, 0, 32'h99, 0);
        step();
        dp_valid_in = 1'b0;
        chk("t6_post_count", 64'(count_out), 64'd1);
        step();
        chk("t6_post_rob",  64'(iss_rob_id_out), 64'd10);
        chk("t6_post_vj",   64'(iss_vj_out), 64'h99);
        chk("t6_post_cnt0", 64'(count_out), 64'd0);
        cdb(0, 5, 32'h12);
        iss_ready_in = 1'b1;
        step();
        cdb_valid_in = '0;
        step();
        chk("t6_no_stale", 64'(iss_valid_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
